// File: rtl/ara_eoc_monitor.sv
// End-of-computation monitor: snoops AXI AW/W for a tohost store, pairs address matches
// with last W beats in order, and measures the runtime window given by the counter enable.
module ara_eoc_monitor #(
    parameter int unsigned                    AxiAddrWidth = 64,
    parameter int unsigned                    AxiDataWidth = 64,
    parameter logic        [AxiAddrWidth-1:0] ToHostAddr   = AxiAddrWidth'(64'h8000_1000),
    parameter int unsigned                    FifoDepth    = 4,
    parameter int unsigned                    CntWidth     = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      aw_valid_i,
    input  logic                      aw_ready_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic                      w_valid_i,
    input  logic                      w_ready_i,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    input  logic                      cnt_en_i,
    output logic [63:0]               exit_o,
    output logic [CntWidth-1:0]       runtime_o,
    output logic                      runtime_valid_o,
    output logic                      running_o,
    output logic                      overflow_o
);

    localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FifoDepth);

    typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

    state_e state_q, state_d;

    // AW FIFO holds one match bit per address; W FIFO holds {data[63:0], strb[7:0]}.
    logic [FifoDepth-1:0]       aw_mem_q;
    logic [PtrW-1:0]            aw_wr_ptr_q, aw_wr_ptr_d, aw_rd_ptr_q, aw_rd_ptr_d;
    logic [PtrW:0]              aw_cnt_q, aw_cnt_d;
    logic [FifoDepth-1:0][71:0] w_mem_q;
    logic [PtrW-1:0]            w_wr_ptr_q, w_wr_ptr_d, w_rd_ptr_q, w_rd_ptr_d;
    logic [PtrW:0]              w_cnt_q, w_cnt_d;
    logic                       overflow_q, overflow_d;

    logic [CntWidth-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CntWidth-1:0] runtime_q, runtime_d;
    logic                runtime_valid_q, runtime_valid_d;
    logic [63:0]         exit_q, exit_d;

    logic        aw_hs, w_hs, aw_match;
    logic [71:0] w_entry, w_head;
    logic        aw_head;
    logic        aw_head_valid, w_head_valid, pair;
    logic        aw_pop, w_pop, aw_bypass, w_bypass, aw_push, w_push, aw_drop, w_drop;
    logic        exit_event;

    logic unused_bits;
    assign unused_bits = ^{aw_addr_i[2:0], w_data_i, w_strb_i};

    // Handshake decode and head selection; an empty FIFO exposes the incoming entry directly
    // so a same-cycle push can pair without a cycle of latency.
    always_comb begin
        aw_hs    = aw_valid_i && aw_ready_i && (state_q != StDone);
        w_hs     = w_valid_i && w_ready_i && w_last_i && (state_q != StDone);
        aw_match = (aw_addr_i[AxiAddrWidth-1:3] == ToHostAddr[AxiAddrWidth-1:3]);
        w_entry  = {w_data_i[63:0], w_strb_i[7:0]};

        aw_head_valid = (aw_cnt_q != '0) || aw_hs;
        w_head_valid  = (w_cnt_q != '0) || w_hs;
        aw_head       = (aw_cnt_q != '0) ? aw_mem_q[aw_rd_ptr_q] : aw_match;
        w_head        = (w_cnt_q != '0) ? w_mem_q[w_rd_ptr_q] : w_entry;
        pair          = aw_head_valid && w_head_valid;

        aw_pop    = pair && (aw_cnt_q != '0);
        w_pop     = pair && (w_cnt_q != '0);
        aw_bypass = pair && (aw_cnt_q == '0);
        w_bypass  = pair && (w_cnt_q == '0);

        // A full FIFO still accepts a push when it pops in the same cycle.
        aw_push = aw_hs && !aw_bypass && ((aw_cnt_q != FullCnt) || aw_pop);
        w_push  = w_hs && !w_bypass && ((w_cnt_q != FullCnt) || w_pop);
        aw_drop = aw_hs && !aw_bypass && (aw_cnt_q == FullCnt) && !aw_pop;
        w_drop  = w_hs && !w_bypass && (w_cnt_q == FullCnt) && !w_pop;

        exit_event = pair && aw_head && (w_head[7:0] == 8'hFF) && w_head[8];

        aw_wr_ptr_d = aw_wr_ptr_q + PtrW'(aw_push);
        aw_rd_ptr_d = aw_rd_ptr_q + PtrW'(aw_pop);
        aw_cnt_d    = aw_cnt_q + (PtrW + 1)'(aw_push) - (PtrW + 1)'(aw_pop);
        w_wr_ptr_d  = w_wr_ptr_q + PtrW'(w_push);
        w_rd_ptr_d  = w_rd_ptr_q + PtrW'(w_pop);
        w_cnt_d     = w_cnt_q + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
        overflow_d  = overflow_q || aw_drop || w_drop;
    end

    // FIFO storage, pointers and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_mem_q    <= '0;
            aw_wr_ptr_q <= '0;
            aw_rd_ptr_q <= '0;
            aw_cnt_q    <= '0;
            w_mem_q     <= '0;
            w_wr_ptr_q  <= '0;
            w_rd_ptr_q  <= '0;
            w_cnt_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (aw_push) aw_mem_q[aw_wr_ptr_q] <= aw_match;
            if (w_push)  w_mem_q[w_wr_ptr_q]   <= w_entry;
            aw_wr_ptr_q <= aw_wr_ptr_d;
            aw_rd_ptr_q <= aw_rd_ptr_d;
            aw_cnt_q    <= aw_cnt_d;
            w_wr_ptr_q  <= w_wr_ptr_d;
            w_rd_ptr_q  <= w_rd_ptr_d;
            w_cnt_q     <= w_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    // Runtime FSM next state; an exit event beats both window start and window end.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        runtime_d       = runtime_q;
        runtime_valid_d = runtime_valid_q;
        exit_d          = exit_q;
        cnt_inc         = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (exit_event) begin
                    exit_d  = w_head[71:8];
                    state_d = StDone;
                end else if (cnt_en_i) begin
                    cnt_d   = CntWidth'(1);
                    state_d = StCount;
                end
            end
            StCount: begin
                if (exit_event) begin
                    exit_d          = w_head[71:8];
                    runtime_d       = cnt_en_i ? cnt_inc : cnt_q;
                    runtime_valid_d = 1'b1;
                    state_d         = StDone;
                end else if (cnt_en_i) begin
                    cnt_d = cnt_inc;
                end else begin
                    runtime_d       = cnt_q;
                    runtime_valid_d = 1'b1;
                    state_d         = StIdle;
                end
            end
            StDone: begin
                // Frozen until reset.
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and measurement registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            runtime_q       <= '0;
            runtime_valid_q <= 1'b0;
            exit_q          <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            runtime_q       <= runtime_d;
            runtime_valid_q <= runtime_valid_d;
            exit_q          <= exit_d;
        end
    end

    assign exit_o          = exit_q;
    assign runtime_o       = runtime_q;
    assign runtime_valid_o = runtime_valid_q;
    assign running_o       = (state_q == StCount);
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_ara_eoc_monitor.sv
// Self-checking bench for ara_eoc_monitor: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ara_eoc_monitor;

    localparam int          DEPTH  = 4;
    localparam logic [63:0] TOHOST = 64'h8000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        aw_valid_i, aw_ready_i, w_valid_i, w_ready_i, w_last_i, cnt_en_i;
    logic [63:0] aw_addr_i, w_data_i;
    logic [7:0]  w_strb_i;
    logic [63:0] exit_o, runtime_o;
    logic        runtime_valid_o, running_o, overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit          aw_q[$];
    logic [71:0] w_q[$];
    bit          m_done, m_count, m_rvalid, m_ovf;
    logic [63:0] m_cnt, m_runtime, m_exit;

    ara_eoc_monitor #(
        .AxiAddrWidth(64),
        .AxiDataWidth(64),
        .ToHostAddr  (TOHOST),
        .FifoDepth   (DEPTH),
        .CntWidth    (64)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .aw_valid_i     (aw_valid_i),
        .aw_ready_i     (aw_ready_i),
        .aw_addr_i      (aw_addr_i),
        .w_valid_i      (w_valid_i),
        .w_ready_i      (w_ready_i),
        .w_data_i       (w_data_i),
        .w_strb_i       (w_strb_i),
        .w_last_i       (w_last_i),
        .cnt_en_i       (cnt_en_i),
        .exit_o         (exit_o),
        .runtime_o      (runtime_o),
        .runtime_valid_o(runtime_valid_o),
        .running_o      (running_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        aw_q.delete();
        w_q.delete();
        m_done = 0; m_count = 0; m_rvalid = 0; m_ovf = 0;
        m_cnt = '0; m_runtime = '0; m_exit = '0;
    endtask

    // Applies the documented rules for one clock edge to the model.
    task automatic model_step();
        bit          aw_new, w_new, pair, ex, am;
        logic [71:0] we;
        if (m_done) return;
        aw_new = aw_valid_i && aw_ready_i;
        w_new  = w_valid_i && w_ready_i && w_last_i;
        pair   = (aw_q.size() + int'(aw_new) > 0) && (w_q.size() + int'(w_new) > 0);
        if (aw_new) begin
            if (aw_q.size() >= DEPTH && !pair) m_ovf = 1;
            else aw_q.push_back(aw_addr_i[63:3] == TOHOST[63:3]);
        end
        if (w_new) begin
            if (w_q.size() >= DEPTH && !pair) m_ovf = 1;
            else w_q.push_back({w_data_i, w_strb_i});
        end
        ex = 0;
        we = '0;
        if (pair) begin
            am = aw_q.pop_front();
            we = w_q.pop_front();
            ex = am && (we[7:0] == 8'hFF) && we[8];
        end
        if (ex) begin
            if (m_count) begin
                m_runtime = cnt_en_i ? ((m_cnt == '1) ? m_cnt : m_cnt + 1) : m_cnt;
                m_rvalid  = 1;
            end
            m_exit  = we[71:8];
            m_done  = 1;
            m_count = 0;
        end else if (!m_count) begin
            if (cnt_en_i) begin
                m_count = 1;
                m_cnt   = 64'd1;
            end
        end else if (cnt_en_i) begin
            if (m_cnt != '1) m_cnt = m_cnt + 1;
        end else begin
            m_runtime = m_cnt;
            m_rvalid  = 1;
            m_count   = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        if (rst_ni) model_step();
        #1;
    endtask

    task automatic set_idle();
        aw_valid_i = 0; aw_ready_i = 0; aw_addr_i = '0;
        w_valid_i = 0; w_ready_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0;
        cnt_en_i = 0;
    endtask

    task automatic drive_aw(input logic [63:0] addr);
        aw_valid_i = 1; aw_ready_i = 1; aw_addr_i = addr;
    endtask

    task automatic drive_w(input logic [63:0] data, input logic [7:0] strb);
        w_valid_i = 1; w_ready_i = 1; w_last_i = 1; w_data_i = data; w_strb_i = strb;
    endtask

    task automatic clear_axi();
        aw_valid_i = 0; aw_ready_i = 0; w_valid_i = 0; w_ready_i = 0; w_last_i = 0;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({exit_o, runtime_o, runtime_valid_o, running_o, overflow_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: exit=%h runtime=%h rv=%b run=%b ovf=%b required all zero",
                     exit_o, runtime_o, runtime_valid_o, running_o, overflow_o);
        end
        repeat (20) cycle();
        n_checks++;
        if (exit_o !== 64'h0 || runtime_valid_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_20: exit=%h rv=%b ovf=%b required 0 0 0",
                     exit_o, runtime_valid_o, overflow_o);
        end
    endtask

    task automatic test_runtime();
        apply_reset();
        cnt_en_i = 1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (i == 50) begin
                n_checks++;
                if (running_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL running_mid_window: running_o=%b required 1", running_o);
                end
            end
        end
        cnt_en_i = 0;
        cycle();
        n_checks++;
        if (runtime_o !== 64'd100 || runtime_valid_o !== 1'b1 || running_o !== 1'b0) begin
            n_errors++;
            $display("FAIL window_100: runtime=%0d rv=%b run=%b required 100 1 0",
                     runtime_o, runtime_valid_o, running_o);
        end
        repeat (3) cycle();
        cnt_en_i = 1;
        repeat (7) cycle();
        cnt_en_i = 0;
        cycle();
        n_checks++;
        if (runtime_o !== 64'd7 || runtime_valid_o !== 1'b1) begin
            n_errors++;
            $display("FAIL window_7: runtime=%0d rv=%b required 7 1", runtime_o, runtime_valid_o);
        end
    endtask

    task automatic test_exit_same_cycle();
        apply_reset();
        drive_aw(TOHOST);
        drive_w(64'h1, 8'hFF);
        cycle();
        clear_axi();
        n_checks++;
        if (exit_o !== 64'h1) begin
            n_errors++;
            $display("FAIL exit_same_cycle: exit_o=%h required %h", exit_o, 64'h1);
        end
        for (int i = 0; i < 12; i++) begin
            cnt_en_i = (i % 5) < 3;
            if (i == 4) begin
                drive_aw(TOHOST);
                drive_w(64'h77, 8'hFF);
            end else begin
                clear_axi();
            end
            cycle();
        end
        n_checks++;
        if (exit_o !== 64'h1 || running_o !== 1'b0 || runtime_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frozen_after_exit: exit=%h run=%b rv=%b required 1 0 0",
                     exit_o, running_o, runtime_valid_o);
        end
    endtask

    task automatic test_w_before_aw();
        apply_reset();
        drive_w(64'h55, 8'hFF);
        cycle();
        clear_axi();
        repeat (2) cycle();
        n_checks++;
        if (exit_o !== 64'h0) begin
            n_errors++;
            $display("FAIL w_early_no_exit: exit_o=%h required 0", exit_o);
        end
        drive_aw(TOHOST);
        cycle();
        clear_axi();
        n_checks++;
        if (exit_o !== 64'h55) begin
            n_errors++;
            $display("FAIL w_before_aw: exit_o=%h required %h", exit_o, 64'h55);
        end
    endtask

    task automatic test_ordering();
        logic [63:0] addrs [3];
        logic [63:0] want [3];
        addrs[0] = 64'h9000_0000; addrs[1] = TOHOST; addrs[2] = 64'h8000_2000;
        want[0] = 64'h0; want[1] = 64'h3; want[2] = 64'h3;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive_aw(addrs[i]);
            drive_w(64'h3, 8'hFF);
            cycle();
            n_checks++;
            if (exit_o !== want[i]) begin
                n_errors++;
                $display("FAIL order_burst%0d: exit_o=%h required %h", i, exit_o, want[i]);
            end
        end
        clear_axi();
        apply_reset();
        drive_aw(TOHOST);
        drive_w(64'h1, 8'h0F);
        cycle();
        drive_aw(TOHOST + 64'h4);
        drive_w(64'h2, 8'hFF);
        cycle();
        clear_axi();
        cycle();
        n_checks++;
        if (exit_o !== 64'h0) begin
            n_errors++;
            $display("FAIL partial_strb_or_even_data: exit_o=%h required 0", exit_o);
        end
    endtask

    task automatic test_exit_in_count();
        apply_reset();
        cnt_en_i = 1;
        repeat (10) cycle();
        drive_aw(TOHOST);
        drive_w(64'h9, 8'hFF);
        cycle();
        clear_axi();
        n_checks++;
        if (runtime_o !== 64'd11 || runtime_valid_o !== 1'b1 || exit_o !== 64'h9
            || running_o !== 1'b0) begin
            n_errors++;
            $display("FAIL exit_in_count_en: runtime=%0d rv=%b exit=%h run=%b required 11 1 9 0",
                     runtime_o, runtime_valid_o, exit_o, running_o);
        end
        apply_reset();
        cnt_en_i = 1;
        repeat (10) cycle();
        cnt_en_i = 0;
        drive_aw(TOHOST);
        drive_w(64'hB, 8'hFF);
        cycle();
        clear_axi();
        repeat (3) cycle();
        n_checks++;
        if (runtime_o !== 64'd10 || runtime_valid_o !== 1'b1 || exit_o !== 64'hB) begin
            n_errors++;
            $display("FAIL exit_on_fall: runtime=%0d rv=%b exit=%h required 10 1 b",
                     runtime_o, runtime_valid_o, exit_o);
        end
        apply_reset();
        cnt_en_i = 1;
        drive_aw(TOHOST);
        drive_w(64'hD, 8'hFF);
        cycle();
        clear_axi();
        n_checks++;
        if (running_o !== 1'b0 || runtime_valid_o !== 1'b0 || exit_o !== 64'hD) begin
            n_errors++;
            $display("FAIL exit_beats_start: run=%b rv=%b exit=%h required 0 0 d",
                     running_o, runtime_valid_o, exit_o);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        drive_aw(64'h1234_0000);
        cycle();
        for (int i = 0; i < 4; i++) begin
            drive_aw(TOHOST);
            cycle();
        end
        clear_axi();
        n_checks++;
        if (overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_set: overflow_o=%b required 1", overflow_o);
        end
        drive_w(64'h1, 8'hFF);
        cycle();
        clear_axi();
        n_checks++;
        if (exit_o !== 64'h0) begin
            n_errors++;
            $display("FAIL overflow_pair_first: exit_o=%h required 0", exit_o);
        end
        drive_w(64'h21, 8'hFF);
        cycle();
        clear_axi();
        n_checks++;
        if (exit_o !== 64'h21 || overflow_o !== 1'b1) begin
            n_errors++;
            $display("FAIL overflow_pair_second: exit=%h ovf=%b required 21 1", exit_o, overflow_o);
        end
        // Reset in the middle of a window with FIFO contents pending.
        apply_reset();
        cnt_en_i = 1;
        drive_aw(TOHOST);
        repeat (6) cycle();
        #2;
        rst_ni = 0;
        model_reset();
        #1;
        n_checks++;
        if ({exit_o, runtime_o, runtime_valid_o, running_o, overflow_o} !== '0) begin
            n_errors++;
            $display("FAIL async_reset: exit=%h runtime=%h rv=%b run=%b ovf=%b required all zero",
                     exit_o, runtime_o, runtime_valid_o, running_o, overflow_o);
        end
        set_idle();
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        drive_w(64'h1, 8'hFF);
        cycle();
        clear_axi();
        repeat (2) cycle();
        n_checks++;
        if (exit_o !== 64'h0 || running_o !== 1'b0 || overflow_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_clears_fifo: exit=%h run=%b ovf=%b required 0 0 0",
                     exit_o, running_o, overflow_o);
        end
    endtask

    task automatic test_random();
        logic [63:0] d;
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            for (int c = 0; c < 300; c++) begin
                aw_valid_i = ($urandom_range(0, 3) == 0);
                aw_ready_i = ($urandom_range(0, 2) != 0);
                aw_addr_i  = ($urandom_range(0, 2) == 0) ? TOHOST + 64'($urandom_range(0, 7))
                                                         : {$urandom, $urandom};
                w_valid_i  = ($urandom_range(0, 2) == 0);
                w_ready_i  = (r % 2 == 0) ? ($urandom_range(0, 4) != 0) : 1'b1;
                w_last_i   = ($urandom_range(0, 1) == 0);
                d          = {$urandom, $urandom};
                d[0]       = ($urandom_range(0, 9) == 0);
                w_data_i   = d;
                w_strb_i   = ($urandom_range(0, 3) == 0) ? 8'h0F : 8'hFF;
                if ($urandom_range(0, 12) == 0) cnt_en_i = ~cnt_en_i;
                cycle();
                n_checks++;
                if ({exit_o, runtime_o, runtime_valid_o, running_o, overflow_o}
                    !== {m_exit, m_runtime, m_rvalid, m_count, m_ovf}) begin
                    n_errors++;
                    $display("FAIL random r%0d c%0d: got exit=%h rt=%0d rv=%b run=%b ovf=%b want exit=%h rt=%0d rv=%b run=%b ovf=%b",
                             r, c, exit_o, runtime_o, runtime_valid_o, running_o, overflow_o,
                             m_exit, m_runtime, m_rvalid, m_count, m_ovf);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        model_reset();
        test_reset();
        test_runtime();
        test_exit_same_cycle();
        test_w_before_aw();
        test_ordering();
        test_exit_in_count();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ara_eoc_monitor.md
Name: ara_eoc_monitor

Overview:
- Passive, synthesizable end-of-computation monitor inside ara_testharness, directly upstream of the top-level bench.
- Snoops the system AXI AW/W channels for a "tohost" store, measures vector hardware runtime from the SoC counter-enable, and produces exit_o and the runtime value.
- The bench consumes both outputs: it finishes on exit_o[0] and prints the runtime.
- It never drives the AXI bus.

Parameters:
- AxiAddrWidth, 64, AXI address width.
- AxiDataWidth, 64, AXI data width; must be ≥64. Only bits [63:0] are used for exit.
- ToHostAddr, 64'h8000_1000, tohost address; AW matches when aw_addr_i[AxiAddrWidth-1:3] == ToHostAddr[AxiAddrWidth-1:3].
- FifoDepth, 4, depth of the AW-match FIFO and of the W-last FIFO; power of two, ≥2.
- CntWidth, 64, runtime counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_valid_i  in  1  AW valid (snooped)
- aw_ready_i  in  1  AW ready (snooped)
- aw_addr_i  in  AxiAddrWidth  AW address
- w_valid_i  in  1  W valid
- w_ready_i  in  1  W ready
- w_data_i  in  AxiDataWidth  W data
- w_strb_i  in  AxiDataWidth/8  W strobe
- w_last_i  in  1  W last
- cnt_en_i  in  1  hardware counter enable (hw_cnt_en[0])
- exit_o  out  64  {exit code, 1'b1} once a tohost exit is seen; 0 otherwise
- runtime_o  out  CntWidth  last latched runtime, in cycles
- runtime_valid_o  out  1  runtime_o holds a completed measurement
- running_o  out  1  FSM is in COUNT
- overflow_o  out  1  sticky: a FIFO push was dropped

Behaviour:
- Reset (async, rst_ni=0): all outputs 0, both FIFOs empty, counter 0, FSM=IDLE. Reset asserted mid-operation aborts immediately; no partial state survives.
- Handshakes: an AW handshake is aw_valid_i&&aw_ready_i; a W handshake is w_valid_i&&w_ready_i.
- AW path: each AW handshake pushes 1 match bit into the AW FIFO.
- W path: each W handshake with w_last_i=1 pushes {w_data_i[63:0], w_strb_i[7:0]} into the W FIFO. Non-last beats are ignored.
- Ordering: W bursts may complete before their AW. Entries pair strictly in order.
- Pairing: when both FIFO heads are valid, pop both in the same cycle. Exit event = match && strb[7:0]==8'hFF && data[0]==1.
- Exit latency: exit_o = data[63:0] is visible in the cycle after the later of the two handshakes, provided the FIFOs were otherwise empty. This requires a bypass for a same-cycle push and pair.
- Full FIFO: a push is dropped and overflow_o is set sticky. Simultaneous push and pop on a full FIFO is allowed and does not overflow.
- Empty FIFO: no pop.
- Both FIFOs wrap modulo FifoDepth.
- FSM IDLE: on cnt_en_i=1, clear counter to 1 and go to COUNT.
- FSM COUNT: counter +1 each cycle with cnt_en_i=1, saturating at all-ones.
  - On cnt_en_i=0: runtime_o<=counter, runtime_valid_o<=1, go to IDLE.
  - A later window overwrites runtime_o. runtime_valid_o stays 1.
- FSM DONE (entered on an exit event from any state): exit_o, runtime_o and runtime_valid_o are frozen until reset. Further AXI traffic and cnt_en_i are ignored.
  - If the exit event occurs in COUNT, runtime_o<=counter (including the current cycle when cnt_en_i=1) and runtime_valid_o<=1.
- Simultaneous events: an exit event in the same cycle as a cnt_en_i fall latches the counter once and goes to DONE. An exit event has priority over window start.
- running_o=1 only while in COUNT.

Test Plan:
- Reset, then idle 20 cycles -> exit_o=0, runtime_valid_o=0, overflow_o=0.
- cnt_en_i high for exactly 100 cycles, then low -> runtime_o=100, runtime_valid_o=1 the cycle after the fall. A second window of 7 cycles -> runtime_o=7.
- AW to 0x8000_1000 with a single-beat W of data=0x1 and strb=0xFF in the same cycle -> exit_o=64'h1 next cycle. Subsequent cnt_en_i activity leaves outputs frozen.
- W last (data=0x55) arrives 3 cycles before its AW to ToHostAddr -> exit_o=64'h55 one cycle after the AW handshake.
- Three AWs (non-match, match, non-match) each with data=0x3 -> exactly one exit event, from the second burst, exit_o=3. A match with strb=0x0F or data=0x2 -> exit_o remains 0.
- 5 AW handshakes with no W, then 1 W last -> overflow_o=1. Pairs use the first 4 AWs in order. Reset mid-window clears all state.
